// File: rtl/spi_expander_pkg.sv
// spi_expander_pkg: shared FSM states, frame geometry and width helpers for the SPI GPIO expander
package spi_expander_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  localparam int CMD_W = 8;
  localparam int ADDR_W = 7;
  localparam int IN_SPACE_BIT = 6;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int w);
    return $clog2(w > CMD_W ? w : CMD_W);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser with rise/fall pulses on the synchronised level
module spi_sync_edge #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) s <= {3{RST_VAL}};
    else s <= {s[1:0], d};
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_expander_mp.sv
// spi_expander_mp: multi-port SPI GPIO expander with output latches, input snapshots and burst access
module spi_expander_mp
  import spi_expander_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int PORT_W = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ss,
  input  logic                      sclk,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  input  logic [N_PORTS*PORT_W-1:0] pin_in,
  output logic [N_PORTS*PORT_W-1:0] pin_out,
  output logic [N_PORTS-1:0]        upd
);
  localparam int IW = idx_w(N_PORTS);
  localparam int CW = cnt_w(PORT_W);
  localparam int RW = PORT_W > CMD_W ? PORT_W : CMD_W;
  localparam logic [ADDR_W-1:0] NP = ADDR_W'(N_PORTS);

  logic ss_q, ss_rise, ss_fall, sclk_q, sclk_rise, sclk_fall, mosi_q, mosi_rise, mosi_fall;
  logic unused;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (.clk(clk), .rst(rst), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
  assign unused = ^{ss_rise, ss_fall, sclk_q, mosi_rise, mosi_fall};

  logic lead, trail, samp, shift;
  assign lead = CPOL ? sclk_fall : sclk_rise;
  assign trail = CPOL ? sclk_rise : sclk_fall;
  assign samp = CPHA ? trail : lead;
  assign shift = CPHA ? lead : trail;

  state_t state;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic rw, miso_q;
  logic [RW-2:0] rx;
  logic [PORT_W-1:0] tx;
  logic [PORT_W-1:0] out_r [N_PORTS];

  logic [ADDR_W-1:0] cmd_addr, rd_addr;
  logic [PORT_W-1:0] word, rd_word;
  logic [IW-1:0] rd_idx, wr_idx;
  logic rd_ok, wr_ok;

  assign cmd_addr = {rx[ADDR_W-2:0], mosi_q};
  assign word = {rx[PORT_W-2:0], mosi_q};
  // Next read word: first word after CMD, otherwise the following address of the burst
  assign rd_addr = state == CMD ? cmd_addr : addr + 7'd1;
  assign rd_idx = rd_addr[IW-1:0];
  assign rd_ok = {1'b0, rd_addr[IN_SPACE_BIT-1:0]} < NP;
  assign wr_idx = addr[IW-1:0];
  assign wr_ok = !addr[IN_SPACE_BIT] && ({1'b0, addr[IN_SPACE_BIT-1:0]} < NP);

  always_comb
    rd_word = !rd_ok ? '0 : rd_addr[IN_SPACE_BIT] ? pin_in[rd_idx*PORT_W +: PORT_W] : out_r[rd_idx];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      rw <= 1'b0;
      rx <= '0;
      tx <= '0;
      miso_q <= 1'b0;
      upd <= '0;
      for (int i = 0; i < N_PORTS; i++) out_r[i] <= '0;
    end else begin
      upd <= '0;
      if (ss_q) begin
        state <= IDLE;
        cnt <= '0;
        tx <= '0;
        miso_q <= 1'b0;
      end else if (state == IDLE) begin
        state <= CMD;
        cnt <= '0;
        tx <= '0;
        miso_q <= 1'b0;
      end else begin
        if (shift) begin
          miso_q <= tx[PORT_W-1];
          tx <= tx << 1;
        end
        if (samp) begin
          rx <= {rx[RW-3:0], mosi_q};
          cnt <= cnt + CW'(1);
          if (state == CMD && cnt == CW'(CMD_W - 1)) begin
            state <= DATA;
            cnt <= '0;
            rw <= rx[CMD_W-2];
            addr <= cmd_addr;
            tx <= rx[CMD_W-2] ? '0 : rd_word;
          end else if (state == DATA && cnt == CW'(PORT_W - 1)) begin
            cnt <= '0;
            addr <= addr + 7'd1;
            tx <= rw ? '0 : rd_word;
            if (rw && wr_ok) begin
              out_r[wr_idx] <= word;
              upd[wr_idx] <= 1'b1;
            end
          end
        end
      end
    end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_out
    assign pin_out[i*PORT_W +: PORT_W] = out_r[i];
  end

  assign miso_oe = ~ss_q;
  assign miso = miso_oe & miso_q;
endmodule

// File: tb/tb_spi_expander_mp.sv
// tb_spi_expander_mp: directed checks across all SPI modes and a 4x12 configuration
module tb_spi_expander_mp;
  localparam int HALF = 50;
  logic clk = 1'b0, rst = 1'b0, mosi = 1'b0;
  logic [4:0] ss = 5'b11111, sclk = 5'b01100, miso, oe;
  logic [47:0] pin_in = '0;
  logic [47:0] po [5];
  logic [3:0] up [5];
  int ucnt [5][4];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g
    localparam int NP = k == 4 ? 4 : 2;
    localparam int W = k == 4 ? 12 : 8;
    localparam bit CP = (k == 2 || k == 3);
    localparam bit CH = (k == 1 || k == 3);
    logic [NP*W-1:0] pout;
    logic [NP-1:0] u;
    spi_expander_mp #(.N_PORTS(NP), .PORT_W(W), .CPOL(CP), .CPHA(CH)) dut (
      .clk(clk), .rst(rst), .ss(ss[k]), .sclk(sclk[k]), .mosi(mosi),
      .miso(miso[k]), .miso_oe(oe[k]), .pin_in(pin_in[NP*W-1:0]),
      .pin_out(pout), .upd(u)
    );
    assign po[k] = 48'(pout);
    assign up[k] = 4'(u);
  end

  always @(posedge clk)
    for (int j = 0; j < 5; j++)
      for (int p = 0; p < 4; p++)
        if (up[j][p]) ucnt[j][p] <= ucnt[j][p] + 1;

  function automatic int w_of(input int k);
    return k == 4 ? 12 : 8;
  endfunction

  // Bus master: n bits from mo (MSB at n-1), miso captured into mi at the master sample edge
  task automatic spi_frame(input int k, input int n, input logic [63:0] mo, output logic [63:0] mi);
    bit pol, pha;
    pol = (k == 2 || k == 3);
    pha = (k == 1 || k == 3);
    mi = '0;
    @(negedge clk);
    ss[k] = 1'b0;
    if (!pha) mosi = mo[n-1];
    #HALF;
    for (int i = n - 1; i >= 0; i--) begin
      if (pha) mosi = mo[i];
      sclk[k] = ~pol;
      if (!pha) mi[i] = miso[k];
      #HALF;
      sclk[k] = pol;
      if (pha) mi[i] = miso[k];
      else if (i > 0) mosi = mo[i-1];
      #HALF;
    end
    ss[k] = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    #23;
    for (int k = 0; k < 5; k++) begin
      total++; if (po[k] !== 48'h0) begin bad++; $display("FAIL reset_pin_out k=%0d got=%h exp=0", k, po[k]); end
      total++; if (oe[k] !== 1'b0) begin bad++; $display("FAIL reset_miso_oe k=%0d got=%b exp=0", k, oe[k]); end
      total++; if (miso[k] !== 1'b0) begin bad++; $display("FAIL reset_miso k=%0d got=%b exp=0", k, miso[k]); end
      total++; if (up[k] !== 4'h0) begin bad++; $display("FAIL reset_upd k=%0d got=%h exp=0", k, up[k]); end
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write(input int k);
    int w, u0, u1;
    logic [63:0] mo, mi;
    logic [11:0] d;
    w = w_of(k);
    d = w == 12 ? 12'h5A5 : 12'h0A5;
    mo = (64'h80 << w) | 64'(d);
    u0 = ucnt[k][0];
    u1 = ucnt[k][1];
    spi_frame(k, 8 + w, mo, mi);
    total++; if (po[k] !== 48'(d)) begin bad++; $display("FAIL write_out k=%0d got=%h exp=%h", k, po[k], 48'(d)); end
    total++; if (ucnt[k][0] - u0 !== 1) begin bad++; $display("FAIL write_upd0 k=%0d got=%0d exp=1", k, ucnt[k][0] - u0); end
    total++; if (ucnt[k][1] - u1 !== 0) begin bad++; $display("FAIL write_upd1 k=%0d got=%0d exp=0", k, ucnt[k][1] - u1); end
    total++; if (mi !== 64'h0) begin bad++; $display("FAIL write_miso_quiet k=%0d got=%h exp=0", k, mi); end
  endtask

  task automatic test_read_in(input int k);
    int w;
    logic [63:0] mo, mi, expv;
    w = w_of(k);
    pin_in = w == 12 ? 48'hA3C123 : 48'h3C77;
    expv = w == 12 ? 64'hA3C : 64'h3C;
    mo = 64'h41 << w;
    spi_frame(k, 8 + w, mo, mi);
    total++; if ((mi & ((64'd1 << w) - 64'd1)) !== expv) begin bad++; $display("FAIL read_in k=%0d got=%h exp=%h", k, mi & ((64'd1 << w) - 64'd1), expv); end
    total++; if ((mi >> w) !== 64'h0) begin bad++; $display("FAIL read_cmd_quiet k=%0d got=%h exp=0", k, mi >> w); end
  endtask

  task automatic test_burst;
    int u0, u1;
    logic [63:0] mi;
    u0 = ucnt[0][0];
    u1 = ucnt[0][1];
    spi_frame(0, 24, 64'h801122, mi);
    total++; if (po[0] !== 48'h2211) begin bad++; $display("FAIL burst_out got=%h exp=2211", po[0]); end
    total++; if (ucnt[0][0] - u0 !== 1) begin bad++; $display("FAIL burst_upd0 got=%0d exp=1", ucnt[0][0] - u0); end
    total++; if (ucnt[0][1] - u1 !== 1) begin bad++; $display("FAIL burst_upd1 got=%0d exp=1", ucnt[0][1] - u1); end
  endtask

  task automatic test_abort;
    int u0;
    logic [63:0] mi;
    u0 = ucnt[0][0];
    spi_frame(0, 13, 64'h101F, mi);
    total++; if (po[0] !== 48'h2211) begin bad++; $display("FAIL abort_out got=%h exp=2211", po[0]); end
    total++; if (ucnt[0][0] - u0 !== 0) begin bad++; $display("FAIL abort_upd got=%0d exp=0", ucnt[0][0] - u0); end
    spi_frame(0, 16, 64'h805A, mi);
    total++; if (po[0] !== 48'h225A) begin bad++; $display("FAIL after_abort_out got=%h exp=225A", po[0]); end
    total++; if (ucnt[0][0] - u0 !== 1) begin bad++; $display("FAIL after_abort_upd got=%0d exp=1", ucnt[0][0] - u0); end
  endtask

  task automatic test_range;
    int u0, u1;
    logic [63:0] mi;
    u0 = ucnt[0][0];
    u1 = ucnt[0][1];
    spi_frame(0, 16, 64'h85FF, mi);
    spi_frame(0, 16, 64'hC0FF, mi);
    total++; if (po[0] !== 48'h225A) begin bad++; $display("FAIL range_out got=%h exp=225A", po[0]); end
    total++; if (ucnt[0][0] - u0 + ucnt[0][1] - u1 !== 0) begin bad++; $display("FAIL range_upd got=%0d exp=0", ucnt[0][0] - u0 + ucnt[0][1] - u1); end
    spi_frame(0, 16, 64'h0500, mi);
    total++; if (mi[7:0] !== 8'h00) begin bad++; $display("FAIL range_read got=%h exp=00", mi[7:0]); end
    spi_frame(0, 24, 64'h000000, mi);
    total++; if (mi[15:0] !== 16'h5A22) begin bad++; $display("FAIL burst_read_out got=%h exp=5A22", mi[15:0]); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] mi;
    @(negedge clk);
    ss[0] = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (oe[0] !== 1'b1) begin bad++; $display("FAIL mid_oe_active got=%b exp=1", oe[0]); end
    #3 rst = 1'b0;
    #1;
    total++; if (po[0] !== 48'h0) begin bad++; $display("FAIL mid_rst_out got=%h exp=0", po[0]); end
    total++; if (oe[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_oe got=%b exp=0", oe[0]); end
    total++; if (up[0] !== 4'h0) begin bad++; $display("FAIL mid_rst_upd got=%h exp=0", up[0]); end
    total++; if (miso[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_miso got=%b exp=0", miso[0]); end
    repeat (5) @(negedge clk);
    total++; if (po[0] !== 48'h0 || oe[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_hold got=%h/%b exp=0/0", po[0], oe[0]); end
    ss[0] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    spi_frame(0, 16, 64'h803C, mi);
    total++; if (po[0] !== 48'h3C) begin bad++; $display("FAIL mid_rst_recover got=%h exp=3C", po[0]); end
  endtask

  initial begin
    test_reset;
    for (int k = 0; k < 5; k++) test_write(k);
    for (int k = 0; k < 5; k++) test_read_in(k);
    test_burst;
    test_abort;
    test_range;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
